// File: rtl/flt2int_pkg.sv
// Shared types and constants for the binary16-to-int16 converter.
// The FSM state encoding and memory map live here so the core and bench agree.
package flt2int_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int IN_ADDR   = 4;
    localparam int OUT_ADDR  = 6;
    localparam int BIAS      = 15;
    localparam int MANT_W    = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_HI = 3'd1,
        RD_LO = 3'd2,
        CALC  = 3'd3,
        WR_HI = 3'd4,
        WR_LO = 3'd5,
        DONE  = 3'd6
    } state_e;

endpackage

// File: rtl/flt2int_dmem.sv
// Single-port byte memory: synchronous write, combinational read.
// The storage array mem_core is left visible for hierarchical preload and inspection.
module flt2int_dmem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem_core [0:DEPTH-1];

    // NOTE: storage has no reset; a reset must leave previously written bytes intact.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_core[addr] <= wdata;
        end
    end

    assign rdata = mem_core[addr];

endmodule

// File: rtl/flt2int_core.sv
// Memory-mapped binary16 to int16 converter: on a req falling edge it reads the float
// from the byte memory, rounds half away from zero, writes the result back and pulses ack.
module flt2int_core
    import flt2int_pkg::*;
#(
    parameter int MEM_DEPTH = flt2int_pkg::MEM_DEPTH,
    parameter int IN_ADDR   = flt2int_pkg::IN_ADDR,
    parameter int OUT_ADDR  = flt2int_pkg::OUT_ADDR
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic ack
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] IN_HI_A  = AW'(IN_ADDR);
    localparam logic [AW-1:0] IN_LO_A  = AW'(IN_ADDR + 1);
    localparam logic [AW-1:0] OUT_HI_A = AW'(OUT_ADDR);
    localparam logic [AW-1:0] OUT_LO_A = AW'(OUT_ADDR + 1);

    // Exponent field at which the significand is already an integer (unbiased e = MANT_W).
    localparam logic [4:0] E_INT  = 5'(BIAS + MANT_W);
    localparam logic [4:0] E_HALF = 5'(BIAS - 1);
    localparam logic [4:0] E_ONE  = 5'(BIAS);

    function automatic logic [15:0] flt2int(input logic [15:0] flt);
        logic        sign;
        logic [4:0]  exp_f;
        logic [10:0] mant;
        logic [21:0] wide;
        logic [4:0]  sh;
        logic [4:0]  rnd_idx;
        logic [15:0] mag;
        logic [15:0] res;
        sign    = flt[15];
        exp_f   = flt[14:10];
        mant    = {|exp_f, flt[9:0]};
        wide    = '0;
        sh      = '0;
        rnd_idx = '0;
        mag     = '0;
        if (exp_f >= E_INT) begin
            sh   = exp_f - E_INT;
            wide = {11'd0, mant} << sh;
            mag  = wide[15:0];
        end else if (exp_f >= E_ONE) begin
            // The bit just below the integer LSB decides rounding half away from zero.
            sh      = E_INT - exp_f;
            rnd_idx = (E_INT - 5'd1) - exp_f;
            mag     = 16'(mant >> sh) + 16'(mant[rnd_idx[3:0]]);
        end else if (exp_f == E_HALF) begin
            mag = 16'(mant[10]);
        end
        if (exp_f == 5'd31) begin
            res = sign ? 16'h8000 : 16'h7FFF;
        end else begin
            res = sign ? (~mag + 16'd1) : mag;
        end
        return res;
    endfunction

    state_e      state_q, state_d;
    logic        req_q;
    logic [7:0]  flt_hi_q, flt_hi_d;
    logic [7:0]  flt_lo_q, flt_lo_d;
    logic [15:0] res_q, res_d;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    flt2int_dmem #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) dm1 (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        flt_hi_d  = flt_hi_q;
        flt_lo_d  = flt_lo_q;
        res_d     = res_q;
        mem_we    = 1'b0;
        mem_addr  = IN_HI_A;
        mem_wdata = 8'd0;
        case (state_q)
            IDLE: begin
                if (req_q && !req) begin
                    state_d = RD_HI;
                end
            end
            RD_HI: begin
                mem_addr = IN_HI_A;
                flt_hi_d = mem_rdata;
                state_d  = RD_LO;
            end
            RD_LO: begin
                mem_addr = IN_LO_A;
                flt_lo_d = mem_rdata;
                state_d  = CALC;
            end
            CALC: begin
                res_d   = flt2int({flt_hi_q, flt_lo_q});
                state_d = WR_HI;
            end
            WR_HI: begin
                mem_we    = 1'b1;
                mem_addr  = OUT_HI_A;
                mem_wdata = res_q[15:8];
                state_d   = WR_LO;
            end
            WR_LO: begin
                mem_we    = 1'b1;
                mem_addr  = OUT_LO_A;
                mem_wdata = res_q[7:0];
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            flt_hi_q <= 8'd0;
            flt_lo_q <= 8'd0;
            res_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            req_q    <= req;
            flt_hi_q <= flt_hi_d;
            flt_lo_q <= flt_lo_d;
            res_q    <= res_d;
        end
    end

    assign ack = (state_q == DONE);

endmodule

// File: tb/tb_flt2int_core.sv
// Directed bench for flt2int_core: hand-computed binary16 vectors, latency,
// single-cycle ack, reset abort and back-to-back requests.
module tb_flt2int_core;

    logic clk;
    logic reset;
    logic req;
    logic ack;

    int n_checks  = 0;
    int n_pass    = 0;
    int ack_count = 0;

    flt2int_core dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .ack   (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack) ack_count = ack_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic convert(input logic [15:0] flt, input logic [15:0] exp, input string tag);
        int lat;
        bit seen;
        dut.dm1.mem_core[4] = flt[15:8];
        dut.dm1.mem_core[5] = flt[7:0];
        dut.dm1.mem_core[6] = 8'hA5;
        dut.dm1.mem_core[7] = 8'h5A;
        req = 1'b1;
        @(negedge clk);
        req  = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat = lat + 1;
            if (ack) seen = 1'b1;
        end
        check({tag, "_latency"}, lat, 32'd7);
        check({tag, "_result"}, {16'd0, dut.dm1.mem_core[6], dut.dm1.mem_core[7]}, {16'd0, exp});
        @(negedge clk);
        check({tag, "_ack_width"}, {31'd0, ack}, 32'd0);
    endtask

    int ack_base;

    initial begin
        reset = 1'b0;
        req   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ack", {31'd0, ack}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        convert(16'h0000, 16'h0000, "zero");
        convert(16'h3C00, 16'h0001, "one");
        convert(16'h3E00, 16'h0002, "one_p5");
        convert(16'h3D00, 16'h0001, "one_p25");
        convert(16'h3F00, 16'h0002, "one_p75");
        convert(16'h4380, 16'h0004, "three_p75");
        convert(16'h4040, 16'h0002, "two_p125");
        convert(16'h4140, 16'h0003, "two_p625");
        convert(16'h4B80, 16'h000F, "fifteen");
        convert(16'h6300, 16'd896, "e9");
        convert(16'h7780, 16'd30720, "e14");
        convert(16'h7B80, 16'hF000, "e15_wrap");
        convert(16'hC200, 16'hFFFD, "neg_three");
        convert(16'h3800, 16'h0001, "half");
        convert(16'h37FF, 16'h0000, "below_half");
        convert(16'h7C00, 16'h7FFF, "pos_inf");
        convert(16'hFC00, 16'h8000, "neg_inf");

        // Abort an operation in CALC with reset.
        dut.dm1.mem_core[4] = 8'h3C;
        dut.dm1.mem_core[5] = 8'h00;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        ack_base = ack_count;
        reset = 1'b0;
        @(negedge clk);
        check("reset_hold_ack", {31'd0, ack}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("reset_abort_no_ack", ack_count - ack_base, 32'd0);

        convert(16'h4380, 16'h0004, "after_reset");

        ack_base = ack_count;
        convert(16'h3E00, 16'h0002, "b2b_first");
        convert(16'hC200, 16'hFFFD, "b2b_second");
        check("b2b_ack_count", ack_count - ack_base, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
